// File: rtl/audio_pkg.sv
// Shared types and constants for the stereo sample scheduler.
package audio_pkg;

  typedef logic [15:0] sample_t;

  typedef struct packed {
    sample_t l;
    sample_t r;
  } stereo_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2
  } state_t;

  localparam sample_t SILENCE      = 16'h8000;
  localparam stereo_t SILENCE_PAIR = '{l: SILENCE, r: SILENCE};

  // A divide value of 0 would make the period a single cycle; treat it as 1.
  function automatic logic [15:0] div_reload(input logic [15:0] rate_div);
    return (rate_div == 16'd0) ? 16'd1 : rate_div;
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// DEPTH x 32-bit synchronous FIFO of stereo pairs with single-cycle flush.
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  stereo_t                    wr_pair,
  input  logic                       pop,
  output stereo_t                    rd_pair,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  stereo_t        mem [DEPTH];
  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           do_push;
  logic           do_pop;

  // Pointers carry one extra bit so full and empty stay distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign rd_pair = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_pair;
  end

endmodule

// File: rtl/audio_sample_sched.sv
// Stereo sample scheduler: FIFO-buffered L/R pairs released once per divided sample period.
// Optional build macro AUDIO_UNDERRUN_CNT_EN adds a saturating underrun_cnt output.
//
// state | meaning
// IDLE  | disabled, outputs at SILENCE, FIFO emptied on entry
// PRIME | filling FIFO up to PRIME_LVL, outputs hold last pair
// RUN   | divider running, one pair popped per tick
module audio_sample_sched
  import audio_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int LOW_WM    = 2,
  parameter int PRIME_LVL = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [15:0] rate_div,
  input  logic        wr_valid,
  input  logic [15:0] wr_l,
  input  logic [15:0] wr_r,
  output logic        wr_ready,
  output logic        sample_req,
  output logic [15:0] audio_data_l,
  output logic [15:0] audio_data_r,
  output logic        sample_strobe,
  output logic        underrun
`ifdef AUDIO_UNDERRUN_CNT_EN
  ,
  output logic [15:0] underrun_cnt
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] LOW_WM_L = LW'(LOW_WM);
  localparam logic [LW-1:0] PRIME_L  = LW'(PRIME_LVL);

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   div_cnt;
  logic [15:0]   div_nxt;
  stereo_t       out_q;
  stereo_t       out_nxt;
  stereo_t       rd_pair;
  logic          strobe_nxt;
  logic          underrun_nxt;
  logic          flush;
  logic          push;
  logic          pop;
  logic          tick;
  logic          full;
  logic          empty;
  logic [LW-1:0] level;

  // Dropping enable flushes in the same cycle that leaves the active states.
  assign flush    = !enable && (state != IDLE);
  assign wr_ready = !full && !flush;
  assign push     = wr_valid && wr_ready;
  assign tick     = (state == RUN) && (div_cnt == 16'd0);

  audio_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .wr_pair ('{l: wr_l, r: wr_r}),
    .pop     (pop),
    .rd_pair (rd_pair),
    .flush   (flush),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_comb begin
    state_nxt    = state;
    div_nxt      = div_cnt;
    out_nxt      = out_q;
    pop          = 1'b0;
    strobe_nxt   = 1'b0;
    underrun_nxt = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      out_nxt   = SILENCE_PAIR;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = PRIME;
          out_nxt   = SILENCE_PAIR;
        end
        PRIME: begin
          if (level >= PRIME_L) begin
            state_nxt = RUN;
            div_nxt   = 16'd0;
          end
        end
        RUN: begin
          if (tick) begin
            div_nxt = div_reload(rate_div);
            if (!empty) begin
              pop        = 1'b1;
              out_nxt    = rd_pair;
              strobe_nxt = 1'b1;
            end else begin
              underrun_nxt = 1'b1;
              state_nxt    = PRIME;
            end
          end else begin
            div_nxt = div_cnt - 16'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      div_cnt       <= 16'd0;
      out_q         <= SILENCE_PAIR;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
      sample_req    <= 1'b0;
    end else begin
      state         <= state_nxt;
      div_cnt       <= div_nxt;
      out_q         <= out_nxt;
      sample_strobe <= strobe_nxt;
      underrun      <= underrun_nxt;
      sample_req    <= enable && (level <= LOW_WM_L);
    end
  end

  assign audio_data_l = out_q.l;
  assign audio_data_r = out_q.r;

`ifdef AUDIO_UNDERRUN_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      underrun_cnt <= 16'd0;
    end else if (underrun_nxt && (underrun_cnt != 16'hFFFF)) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_audio_sample_sched.sv
// Directed self-checking bench for audio_sample_sched (default parameters).
module tb_audio_sample_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] rate_div;
  logic        wr_valid;
  logic [15:0] wr_l;
  logic [15:0] wr_r;
  logic        wr_ready;
  logic        sample_req;
  logic [15:0] audio_data_l;
  logic [15:0] audio_data_r;
  logic        sample_strobe;
  logic        underrun;
`ifdef AUDIO_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_sample_sched dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .rate_div      (rate_div),
    .wr_valid      (wr_valid),
    .wr_l          (wr_l),
    .wr_r          (wr_r),
    .wr_ready      (wr_ready),
    .sample_req    (sample_req),
    .audio_data_l  (audio_data_l),
    .audio_data_r  (audio_data_r),
    .sample_strobe (sample_strobe),
    .underrun      (underrun)
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    .underrun_cnt  (underrun_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_pair(input logic [15:0] l, input logic [15:0] r, output logic rdy);
    wr_valid = 1'b1;
    wr_l     = l;
    wr_r     = r;
    #0;
    rdy      = wr_ready;
    step();
    wr_valid = 1'b0;
  endtask

  // Steps until a strobe or underrun shows up; n is the number of edges taken (40 = gave up).
  task automatic wait_evt(output int n, output logic s, output logic u);
    n = 0;
    s = 1'b0;
    u = 1'b0;
    while (n < 40 && !s && !u) begin
      step();
      n++;
      s = sample_strobe;
      u = underrun;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   acc;
    int   cnt;
    logic s;
    logic u;
    logic rdy;

    rst = 1'b1; enable = 1'b0; rate_div = 16'd3;
    wr_valid = 1'b0; wr_l = 16'd0; wr_r = 16'd0;
    step(); step();
    check("rst_l",        32'(audio_data_l),  32'h8000);
    check("rst_r",        32'(audio_data_r),  32'h8000);
    check("rst_wr_ready", 32'(wr_ready),      1);
    check("rst_req",      32'(sample_req),    0);
    check("rst_strobe",   32'(sample_strobe), 0);
    check("rst_underrun", 32'(underrun),      0);
    rst = 1'b0;

    // prime with 4 pairs at rate_div=3
    enable = 1'b1;
    for (int i = 0; i < 4; i++) put_pair(16'(16'h1110 + i), 16'(16'h2220 + i), rdy);
    check("req_full", 32'(sample_req), 0);
    wait_evt(n, s, u);
    check("p0_lat", 32'(n), 2);
    check("p0_l",   32'(audio_data_l), 32'h1110);
    check("p0_r",   32'(audio_data_r), 32'h2220);
    wait_evt(n, s, u);
    check("p1_gap", 32'(n), 4);
    check("p1_l",   32'(audio_data_l), 32'h1111);
    check("p1_r",   32'(audio_data_r), 32'h2221);
    check("req_lvl3", 32'(sample_req), 0);
    step();
    check("req_lvl2", 32'(sample_req), 1);

    // rate change mid-RUN: current interval still 4, then 2
    rate_div = 16'd0;
    wait_evt(n, s, u);
    check("p2_gap", 32'(n), 3);
    check("p2_l",   32'(audio_data_l), 32'h1112);
    wait_evt(n, s, u);
    check("p3_gap", 32'(n), 2);
    check("p3_l",   32'(audio_data_l), 32'h1113);

    // underrun on the next empty tick
    wait_evt(n, s, u);
    check("ur_gap",    32'(n), 2);
    check("ur_pulse",  32'(u), 1);
    check("ur_strobe", 32'(s), 0);
    check("ur_hold_l", 32'(audio_data_l), 32'h1113);
    check("ur_hold_r", 32'(audio_data_r), 32'h2223);
`ifdef AUDIO_UNDERRUN_CNT_EN
    check("ur_cnt1", 32'(underrun_cnt), 1);
`endif
    step();
    check("ur_once", 32'(underrun), 0);

    // back in PRIME: 3 pairs are not enough to restart
    for (int i = 0; i < 3; i++) put_pair(16'(16'h3330 + i), 16'(16'h4440 + i), rdy);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (sample_strobe) cnt++;
    end
    check("prime_nostrobe", 32'(cnt), 0);
    check("prime_hold_l",   32'(audio_data_l), 32'h1113);

    // disable with 3 queued; a write in the flush cycle is dropped
    enable   = 1'b0;
    wr_valid = 1'b1;
    wr_l     = 16'hDEAD;
    wr_r     = 16'hBEEF;
    #1;
    check("flush_wr_ready", 32'(wr_ready), 0);
    step();
    wr_valid = 1'b0;
    check("dis_l",        32'(audio_data_l), 32'h8000);
    check("dis_r",        32'(audio_data_r), 32'h8000);
    check("dis_wr_ready", 32'(wr_ready),     1);
    check("dis_req",      32'(sample_req),   0);

    // fill past DEPTH while idle; extra pairs are dropped
    rate_div = 16'hFFFF;
    acc = 0;
    for (int i = 0; i < 10; i++) begin
      put_pair(16'(16'hA000 + i), 16'(16'hB000 + i), rdy);
      if (rdy) acc++;
      if (i == 7) check("full_rdy7", 32'(rdy), 1);
      if (i == 8) check("full_rdy8", 32'(rdy), 0);
    end
    check("full_accepted", 32'(acc), 8);
    check("full_wr_ready", 32'(wr_ready), 0);

    rate_div = 16'd1;
    enable   = 1'b1;
    wait_evt(n, s, u);
    check("f0_lat", 32'(n), 3);
    check("f0_l",   32'(audio_data_l), 32'hA000);
    check("f0_r",   32'(audio_data_r), 32'hB000);
    for (int i = 1; i < 8; i++) begin
      wait_evt(n, s, u);
      check("fi_gap", 32'(n), 2);
      check("fi_l",   32'(audio_data_l), 32'(16'hA000 + i));
      check("fi_r",   32'(audio_data_r), 32'(16'hB000 + i));
    end
    wait_evt(n, s, u);
    check("f_end_underrun", 32'(u), 1);
    check("f_end_strobe",   32'(s), 0);
    check("f_end_hold",     32'(audio_data_l), 32'hA007);
`ifdef AUDIO_UNDERRUN_CNT_EN
    check("ur_cnt2", 32'(underrun_cnt), 2);
`endif

    // restart, then reset mid-playback
    for (int i = 0; i < 4; i++) put_pair(16'(16'hC000 + i), 16'(16'hD000 + i), rdy);
    wait_evt(n, s, u);
    check("g0_lat", 32'(n), 2);
    check("g0_l",   32'(audio_data_l), 32'hC000);
    rst = 1'b1;
    step();
    check("mrst_l",        32'(audio_data_l),  32'h8000);
    check("mrst_r",        32'(audio_data_r),  32'h8000);
    check("mrst_wr_ready", 32'(wr_ready),      1);
    check("mrst_req",      32'(sample_req),    0);
    check("mrst_strobe",   32'(sample_strobe), 0);
`ifdef AUDIO_UNDERRUN_CNT_EN
    check("mrst_cnt", 32'(underrun_cnt), 0);
`endif
    rst = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
